// File: rtl/coh_noc_pkg.sv
// Shared types for the coherent-NoC timeout recovery path:
// timeout event bundle, recovery FSM states, retry-table entry.
package coh_noc_pkg;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [11:0] txn_id;
        logic [7:0]  src;
        logic [7:0]  tgt;
        logic [47:0] addr;
    } tmo_evt_t;

    localparam int TMO_EVT_W = $bits(tmo_evt_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_BACKOFF,
        ST_RETRY,
        ST_REPORT
    } rec_state_t;

    typedef struct packed {
        logic             valid;
        logic [11:0]      id;
        logic [CNT_W-1:0] cnt;
    } retry_ent_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // base << (cnt-1), clamped to the 16-bit counter range
    function automatic logic [15:0] backoff_cycles(
        input int unsigned      base,
        input logic [CNT_W-1:0] cnt
    );
        logic [31:0] v;
        int unsigned sh;
        sh = (cnt == '0) ? 0 : 32'(cnt) - 1;
        if (base == 0) return 16'h0000;
        if (base > 32'hFFFF || sh >= 16) return 16'hFFFF;
        v = base << sh;
        return (v > 32'hFFFF) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/timeout_event_fifo.sv
// Circular event queue; a push while full succeeds only
// when a pop happens in the same cycle.
module timeout_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 76
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/timeout_recovery_controller.sv
// Queues timeout events, retries them with exponential backoff
// per txn_id, and escalates to a fatal report past the retry limit.
module timeout_recovery_controller
    import coh_noc_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_RETRIES  = 2,
    parameter int TABLE_SIZE   = 16,
    parameter int BACKOFF_BASE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timeout_valid,
    input  logic [11:0] timeout_txn_id,
    input  logic [7:0]  timeout_src_id,
    input  logic [7:0]  timeout_tgt_id,
    input  logic [47:0] timeout_addr,
    input  logic        warning_valid,
    input  logic [11:0] warning_txn_id,
    input  logic        txn_done,
    input  logic [11:0] txn_done_id,
    output logic        recovery_action,
    output logic [11:0] recovery_txn_id,
    output logic        retry_valid,
    input  logic        retry_ready,
    output logic [11:0] retry_txn_id,
    output logic [7:0]  retry_src_id,
    output logic [7:0]  retry_tgt_id,
    output logic [47:0] retry_addr,
    output logic        err_valid,
    input  logic        err_ready,
    output logic [11:0] err_txn_id,
    output logic [7:0]  err_src_id,
    output logic [47:0] err_addr,
    output logic [15:0] retry_cnt,
    output logic [15:0] fatal_cnt,
    output logic [15:0] drop_cnt,
    output logic        fifo_full
);
    localparam int IW = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;

    rec_state_t       state;
    tmo_evt_t         push_evt;
    tmo_evt_t         head;
    tmo_evt_t         work;
    retry_ent_t       tbl [TABLE_SIZE];
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic             lk_hit;
    logic [IW-1:0]    lk_idx;
    logic             free_ok;
    logic [IW-1:0]    free_idx;
    logic             warn_sup;
    logic [CNT_W-1:0] lk_cnt;
    logic [CNT_W-1:0] new_cnt;
    logic             go_report;
    logic [IW-1:0]    wr_idx;
    logic [15:0]      bo;
    logic [15:0]      bo_cnt;
    logic             hold_hit;
    logic [IW-1:0]    hold_idx;

    assign push_evt = '{txn_id: timeout_txn_id, src: timeout_src_id,
                        tgt: timeout_tgt_id, addr: timeout_addr};
    assign pop  = (state == ST_IDLE) && !fifo_empty;
    assign drop = timeout_valid && fifo_full && !pop;

    timeout_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TMO_EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (timeout_valid),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // descending scan leaves the lowest matching index
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        warn_sup = 1'b0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (tbl[i].valid && tbl[i].id == work.txn_id) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
            if (!tbl[i].valid) begin
                free_ok  = 1'b1;
                free_idx = IW'(i);
            end
            if (tbl[i].valid && tbl[i].id == warning_txn_id &&
                tbl[i].cnt >= CNT_W'(MAX_RETRIES))
                warn_sup = 1'b1;
        end
    end

    assign lk_cnt    = tbl[lk_idx].cnt;
    assign new_cnt   = lk_hit ? lk_cnt + CNT_W'(1) : CNT_W'(1);
    assign go_report = lk_hit ? (lk_cnt >= CNT_W'(MAX_RETRIES)) : !free_ok;
    assign wr_idx    = lk_hit ? lk_idx : free_idx;
    assign bo        = backoff_cycles(32'(BACKOFF_BASE), new_cnt);

    assign retry_txn_id = work.txn_id;
    assign retry_src_id = work.src;
    assign retry_tgt_id = work.tgt;
    assign retry_addr   = work.addr;
    assign err_txn_id   = work.txn_id;
    assign err_src_id   = work.src;
    assign err_addr     = work.addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            work            <= '0;
            bo_cnt          <= '0;
            hold_hit        <= 1'b0;
            hold_idx        <= '0;
            recovery_action <= 1'b0;
            recovery_txn_id <= '0;
            retry_valid     <= 1'b0;
            err_valid       <= 1'b0;
            retry_cnt       <= '0;
            fatal_cnt       <= '0;
            drop_cnt        <= '0;
            for (int i = 0; i < TABLE_SIZE; i++) tbl[i] <= '0;
        end else begin
            recovery_action <= warning_valid && !warn_sup;
            if (warning_valid) recovery_txn_id <= warning_txn_id;
            if (drop) drop_cnt <= sat_inc16(drop_cnt);
            for (int i = 0; i < TABLE_SIZE; i++)
                if (txn_done && tbl[i].valid && tbl[i].id == txn_done_id)
                    tbl[i].valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        work  <= head;
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    hold_hit <= lk_hit;
                    hold_idx <= lk_idx;
                    if (go_report) begin
                        err_valid <= 1'b1;
                        state     <= ST_REPORT;
                    end else begin
                        // placed after the txn_done loop so this write wins
                        tbl[wr_idx] <= '{valid: 1'b1, id: work.txn_id,
                                         cnt: new_cnt};
                        if (bo == 16'h0000) begin
                            retry_valid <= 1'b1;
                            state       <= ST_RETRY;
                        end else begin
                            bo_cnt <= bo;
                            state  <= ST_BACKOFF;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (bo_cnt < 16'd2) begin
                        bo_cnt      <= '0;
                        retry_valid <= 1'b1;
                        state       <= ST_RETRY;
                    end else begin
                        bo_cnt <= bo_cnt - 16'd1;
                    end
                end
                ST_RETRY: begin
                    if (retry_ready) begin
                        retry_valid <= 1'b0;
                        retry_cnt   <= sat_inc16(retry_cnt);
                        state       <= ST_IDLE;
                    end
                end
                ST_REPORT: begin
                    if (err_ready) begin
                        err_valid <= 1'b0;
                        fatal_cnt <= sat_inc16(fatal_cnt);
                        if (hold_hit) tbl[hold_idx].valid <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timeout_recovery_controller.sv
// Directed bench for timeout_recovery_controller with a
// queue/map reference model checked every cycle.
`timescale 1ns/1ps
module tb_timeout_recovery_controller;

    localparam int DEPTH = 8;
    localparam int MAXR  = 2;
    localparam int TSIZE = 16;
    localparam int BASE  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timeout_valid = 1'b0;
    logic [11:0] timeout_txn_id = '0;
    logic [7:0]  timeout_src_id = '0;
    logic [7:0]  timeout_tgt_id = '0;
    logic [47:0] timeout_addr = '0;
    logic        warning_valid = 1'b0;
    logic [11:0] warning_txn_id = '0;
    logic        txn_done = 1'b0;
    logic [11:0] txn_done_id = '0;
    logic        recovery_action;
    logic [11:0] recovery_txn_id;
    logic        retry_valid;
    logic        retry_ready = 1'b1;
    logic [11:0] retry_txn_id;
    logic [7:0]  retry_src_id;
    logic [7:0]  retry_tgt_id;
    logic [47:0] retry_addr;
    logic        err_valid;
    logic        err_ready = 1'b1;
    logic [11:0] err_txn_id;
    logic [7:0]  err_src_id;
    logic [47:0] err_addr;
    logic [15:0] retry_cnt;
    logic [15:0] fatal_cnt;
    logic [15:0] drop_cnt;
    logic        fifo_full;

    always #5 clk = ~clk;

    timeout_recovery_controller #(
        .FIFO_DEPTH   (DEPTH),
        .MAX_RETRIES  (MAXR),
        .TABLE_SIZE   (TSIZE),
        .BACKOFF_BASE (BASE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .timeout_valid   (timeout_valid),
        .timeout_txn_id  (timeout_txn_id),
        .timeout_src_id  (timeout_src_id),
        .timeout_tgt_id  (timeout_tgt_id),
        .timeout_addr    (timeout_addr),
        .warning_valid   (warning_valid),
        .warning_txn_id  (warning_txn_id),
        .txn_done        (txn_done),
        .txn_done_id     (txn_done_id),
        .recovery_action (recovery_action),
        .recovery_txn_id (recovery_txn_id),
        .retry_valid     (retry_valid),
        .retry_ready     (retry_ready),
        .retry_txn_id    (retry_txn_id),
        .retry_src_id    (retry_src_id),
        .retry_tgt_id    (retry_tgt_id),
        .retry_addr      (retry_addr),
        .err_valid       (err_valid),
        .err_ready       (err_ready),
        .err_txn_id      (err_txn_id),
        .err_src_id      (err_src_id),
        .err_addr        (err_addr),
        .retry_cnt       (retry_cnt),
        .fatal_cnt       (fatal_cnt),
        .drop_cnt        (drop_cnt),
        .fifo_full       (fifo_full)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int     id;
        int     src;
        int     tgt;
        longint addr;
    } ev_t;

    ev_t    q[$];
    int     tbl[int];
    ev_t    job;
    bit     busy = 0;
    bit     waiting = 0;
    longint mcyc = 0;
    longint look_at = 0;
    longint val_at = 0;
    bit     m_rv = 0;
    bit     m_ev = 0;
    bit     m_ra = 0;
    int     m_rid = 0;
    int     m_rc = 0;
    int     m_fc = 0;
    int     m_dc = 0;

    task automatic m_reset();
        q.delete();
        tbl.delete();
        busy = 0; waiting = 0; mcyc = 0;
        m_rv = 0; m_ev = 0; m_ra = 0; m_rid = 0;
        m_rc = 0; m_fc = 0; m_dc = 0;
    endtask

    task automatic m_step();
        bit     was_busy;
        bit     do_wr;
        int     newc;
        int     wid;
        longint b;
        ev_t    e;
        mcyc++;
        was_busy = busy;
        wid = int'(warning_txn_id);
        m_ra = warning_valid && !(tbl.exists(wid) && tbl[wid] >= MAXR);
        if (warning_valid) m_rid = wid;
        if (m_rv && retry_ready) begin
            m_rv = 0; busy = 0;
            if (m_rc < 65535) m_rc++;
        end
        if (m_ev && err_ready) begin
            m_ev = 0; busy = 0;
            if (m_fc < 65535) m_fc++;
            if (tbl.exists(job.id)) tbl.delete(job.id);
        end
        do_wr = 0;
        newc = 0;
        if (busy && mcyc == look_at) begin
            if (tbl.exists(job.id) && tbl[job.id] >= MAXR) m_ev = 1;
            else if (tbl.exists(job.id)) begin
                do_wr = 1; newc = tbl[job.id] + 1;
            end else if (tbl.num() < TSIZE) begin
                do_wr = 1; newc = 1;
            end else m_ev = 1;
            if (do_wr) begin
                b = longint'(BASE) * longint'(2 ** (newc - 1));
                if (b > 65535) b = 65535;
                val_at = mcyc + b;
                waiting = 1;
            end
        end
        if (txn_done && tbl.exists(int'(txn_done_id)))
            tbl.delete(int'(txn_done_id));
        if (do_wr) tbl[job.id] = newc;
        if (waiting && mcyc >= val_at) begin
            waiting = 0; m_rv = 1;
        end
        if (!was_busy && q.size() > 0) begin
            job = q.pop_front();
            busy = 1;
            look_at = mcyc + 1;
        end
        if (timeout_valid) begin
            if (q.size() < DEPTH) begin
                e.id = int'(timeout_txn_id);
                e.src = int'(timeout_src_id);
                e.tgt = int'(timeout_tgt_id);
                e.addr = longint'(timeout_addr);
                q.push_back(e);
            end else if (m_dc < 65535) m_dc++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) m_reset();
        else m_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("retry_valid", retry_valid, m_rv);
            chk("err_valid", err_valid, m_ev);
            chk("recovery_action", recovery_action, m_ra);
            chk("fifo_full", fifo_full, q.size() == DEPTH);
            chk("retry_cnt", retry_cnt, m_rc);
            chk("fatal_cnt", fatal_cnt, m_fc);
            chk("drop_cnt", drop_cnt, m_dc);
            if (m_ra) chk("recovery_txn_id", recovery_txn_id, m_rid);
            if (m_rv) begin
                chk("retry_txn_id", retry_txn_id, job.id);
                chk("retry_src_id", retry_src_id, job.src);
                chk("retry_tgt_id", retry_tgt_id, job.tgt);
                chk("retry_addr", retry_addr, job.addr);
            end
            if (m_ev) begin
                chk("err_txn_id", err_txn_id, job.id);
                chk("err_src_id", err_src_id, job.src);
                chk("err_addr", err_addr, job.addr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_to(input logic [11:0] id, input logic [7:0] s,
                           input logic [7:0] t, input logic [47:0] a);
        timeout_valid  = 1'b1;
        timeout_txn_id = id;
        timeout_src_id = s;
        timeout_tgt_id = t;
        timeout_addr   = a;
        @(negedge clk);
        timeout_valid  = 1'b0;
    endtask

    task automatic warn(input logic [11:0] id);
        warning_valid  = 1'b1;
        warning_txn_id = id;
        @(negedge clk);
        warning_valid  = 1'b0;
    endtask

    task automatic wait_for(input bit want_err, input int bound);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < bound) begin
            if (want_err ? err_valid : retry_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: err=%0d not seen within %0d cycles",
                     want_err, bound);
        end
    endtask

    task automatic retry_one(input logic [11:0] id, input int bound);
        send_to(id, 8'h01, 8'h02, {36'h0, id});
        wait_for(1'b0, bound);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0;
        bit saw;
        repeat (3) @(negedge clk);
        chk("rst_retry_valid", retry_valid, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_stats", {retry_cnt, fatal_cnt, drop_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single timeout, ready high
        t0 = cyc;
        send_to(12'h123, 8'h11, 8'h22, 48'hABCD_0000_1234);
        wait_for(1'b0, 60);
        chk("t1_rise_delay", cyc - t0 - 1, 18);
        chk("t1_retry_id", retry_txn_id, 12'h123);
        chk("t1_retry_addr", retry_addr, 48'hABCD_0000_1234);
        repeat (2) @(negedge clk);
        chk("t1_retry_cnt", retry_cnt, 1);
        chk("t1_retry_low", retry_valid, 0);

        // second and third timeout of the same id
        t0 = cyc;
        send_to(12'h123, 8'h11, 8'h22, 48'hABCD_0000_1234);
        wait_for(1'b0, 80);
        chk("t2_rise_delay", cyc - t0 - 1, 34);
        repeat (2) @(negedge clk);
        chk("t2_retry_cnt", retry_cnt, 2);
        t0 = cyc;
        send_to(12'h123, 8'h11, 8'h22, 48'hABCD_0000_1234);
        wait_for(1'b1, 20);
        chk("t2_err_delay", cyc - t0 - 1, 2);
        chk("t2_err_id", err_txn_id, 12'h123);
        chk("t2_err_addr", err_addr, 48'hABCD_0000_1234);
        repeat (2) @(negedge clk);
        chk("t2_fatal_cnt", fatal_cnt, 1);

        // back-pressure on the retry port
        retry_ready = 1'b0;
        send_to(12'h200, 8'h33, 8'h44, 48'h0000_0000_2000);
        wait_for(1'b0, 60);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", retry_valid, 1);
            chk("t3_hold_id", retry_txn_id, 12'h200);
            chk("t3_hold_addr", retry_addr, 48'h0000_0000_2000);
        end
        retry_ready = 1'b1;
        @(negedge clk);
        chk("t3_done_valid", retry_valid, 0);
        chk("t3_retry_cnt", retry_cnt, 3);

        // flood the queue while the FSM is stalled
        retry_ready = 1'b0;
        send_to(12'h300, 8'h55, 8'h66, 48'h0000_0000_3000);
        wait_for(1'b0, 60);
        for (int i = 0; i < 10; i++) begin
            timeout_valid  = 1'b1;
            timeout_txn_id = 12'(12'h400 + i);
            timeout_addr   = 48'(48'h4000 + i);
            @(negedge clk);
            if (i == 6) chk("t4_not_full_7", fifo_full, 0);
            if (i == 7) chk("t4_full_8", fifo_full, 1);
        end
        timeout_valid = 1'b0;
        chk("t4_drop_cnt", drop_cnt, 2);
        retry_ready = 1'b1;
        @(negedge clk);
        send_to(12'h40A, 8'h01, 8'h02, 48'h0000_0000_400A);
        chk("t4_pushpop_drop", drop_cnt, 2);
        chk("t4_pushpop_full", fifo_full, 1);
        repeat (220) @(negedge clk);
        chk("t4_drained_cnt", retry_cnt, 13);
        chk("t4_drained_full", fifo_full, 0);

        // warnings
        warn(12'h045);
        chk("t5_pulse", recovery_action, 1);
        chk("t5_pulse_id", recovery_txn_id, 12'h045);
        @(negedge clk);
        chk("t5_pulse_once", recovery_action, 0);
        retry_one(12'h045, 60);
        retry_one(12'h045, 80);
        chk("t5_retry_cnt", retry_cnt, 15);
        warn(12'h045);
        chk("t5_suppressed", recovery_action, 0);
        txn_done = 1'b1;
        txn_done_id = 12'h045;
        @(negedge clk);
        txn_done = 1'b0;
        warn(12'h045);
        chk("t5_after_done", recovery_action, 1);

        // txn_done colliding with the LOOKUP write of the same id
        send_to(12'h200, 8'h33, 8'h44, 48'h0000_0000_2000);
        @(negedge clk);
        txn_done = 1'b1;
        txn_done_id = 12'h200;
        @(negedge clk);
        txn_done = 1'b0;
        wait_for(1'b0, 80);
        repeat (2) @(negedge clk);
        warn(12'h200);
        chk("t5_lookup_wins", recovery_action, 0);

        // fill the table, then overflow it into a report
        for (int i = 0; i < 5; i++) retry_one(12'(12'h500 + i), 60);
        chk("t6_retry_cnt", retry_cnt, 21);
        err_ready = 1'b0;
        send_to(12'h505, 8'h77, 8'h02, 48'h0000_0000_5050);
        wait_for(1'b1, 20);
        repeat (5) @(negedge clk);
        chk("t6_err_hold", err_valid, 1);
        chk("t6_err_id", err_txn_id, 12'h505);
        chk("t6_err_src", err_src_id, 8'h77);
        err_ready = 1'b1;
        @(negedge clk);
        chk("t6_err_done", err_valid, 0);
        chk("t6_fatal_cnt", fatal_cnt, 2);

        // reset in the middle of a backoff
        send_to(12'h300, 8'h55, 8'h66, 48'h0000_0000_3000);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valids", {retry_valid, err_valid, recovery_action,
                              fifo_full}, 0);
        chk("t7_rst_ids", {recovery_txn_id, retry_txn_id, err_txn_id}, 0);
        chk("t7_rst_addr", retry_addr, 0);
        chk("t7_rst_stats", {retry_cnt, fatal_cnt, drop_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (60) begin
            @(negedge clk);
            if (retry_valid) saw = 1;
        end
        chk("t7_no_retry", saw, 0);
        chk("t7_retry_cnt", retry_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timeout_recovery_controller.md
TIMEOUT_RECOVERY_CONTROLLER -- requirements
Module: timeout_recovery_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, timeout-event queue depth (power of 2).
REQ-002 SHALL have parameter MAX_RETRIES, default 2, retries allowed per txn_id before fatal report.
REQ-003 SHALL have parameter TABLE_SIZE, default 16, retry-count table entries.
REQ-004 SHALL have parameter BACKOFF_BASE, default 16, base backoff in cycles.
REQ-005 SHALL have ports: clk input 1 clock; rst_n input 1 asynchronous active-low reset.
REQ-006 SHALL have inputs timeout_valid 1, timeout_txn_id 12, timeout_src_id 8, timeout_tgt_id 8, timeout_addr 48, carrying the one-cycle timeout event from the timeout handler.
REQ-007 SHALL have inputs warning_valid 1, warning_txn_id 12, carrying the pre-timeout warning pulse.
REQ-008 SHALL have inputs txn_done 1, txn_done_id 12, carrying the transaction completion pulse.
REQ-009 SHALL have outputs recovery_action 1, recovery_txn_id 12, the timer-extend request back to the timeout handler.
REQ-010 SHALL have retry_valid output 1, retry_ready input 1, and outputs retry_txn_id 12, retry_src_id 8, retry_tgt_id 8, retry_addr 48, forming the reissue request to the source node.
REQ-011 SHALL have err_valid output 1, err_ready input 1, and outputs err_txn_id 12, err_src_id 8, err_addr 48, forming the fatal error report.
REQ-012 SHALL have outputs retry_cnt 16, fatal_cnt 16, drop_cnt 16 (statistics) and fifo_full 1.

Function
REQ-013 SHALL push {txn_id, src, tgt, addr} into the FIFO on timeout_valid when not full; when full, the event SHALL be dropped and drop_cnt incremented.
REQ-014 SHALL assert recovery_action one cycle after warning_valid, with recovery_txn_id = warning_txn_id, for exactly one cycle, unless the id is in the table with count >= MAX_RETRIES (then suppressed).
REQ-015 SHALL implement FSM states IDLE, LOOKUP, BACKOFF, RETRY, REPORT.
REQ-016 In IDLE with FIFO non-empty, the block SHALL pop the head into a working register and go to LOOKUP next cycle.
REQ-017 In LOOKUP, on a table hit with count >= MAX_RETRIES, the block SHALL go to REPORT.
REQ-018 In LOOKUP, on a hit with count < MAX_RETRIES, the block SHALL increment count and go to BACKOFF.
REQ-019 In LOOKUP, on a miss, the block SHALL allocate the lowest free entry with count=1 and go to BACKOFF; with no free entry it SHALL go to REPORT.
REQ-020 BACKOFF SHALL load a 16-bit down-counter with BACKOFF_BASE << (count-1), saturating at 16'hFFFF, and SHALL enter RETRY when the counter reaches 0.
REQ-021 In RETRY, retry_valid SHALL be high and the payload SHALL be held stable until retry_valid && retry_ready; on that cycle retry_cnt SHALL increment and the FSM SHALL go to IDLE.
REQ-022 In REPORT, err_valid SHALL be held with a stable payload until err_ready; on that handshake fatal_cnt SHALL increment, the matching table entry (if any) SHALL be invalidated, and the FSM SHALL go to IDLE.
REQ-023 txn_done SHALL invalidate a matching table entry; if it targets the entry being written in LOOKUP in the same cycle, the LOOKUP write SHALL win.
REQ-024 Simultaneous push and pop SHALL both succeed when the FIFO is full, with no drop.
REQ-025 Statistics counters SHALL saturate at 16'hFFFF.
REQ-026 fifo_full SHALL be a registered-state combinational flag, high when occupancy equals FIFO_DEPTH.

Reset
REQ-027 On rst_n low, all outputs SHALL be 0, the FIFO SHALL be empty, all table entries SHALL be invalid, counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-028 A reset during BACKOFF, RETRY or REPORT SHALL abort the operation without completing a handshake after release.

Structure
REQ-029 The timeout event struct (txn_id, src, tgt, addr) and the FSM state enum SHALL reside in coh_noc_pkg.
REQ-030 The FIFO SHALL be a sub-module, timeout_event_fifo, parameterised by depth and the struct type width.

Verification
REQ-031 Single timeout id 0x123 with retry_ready=1: retry_valid SHALL rise 1 (pop) + 1 (LOOKUP) + 16 backoff cycles later, carrying id 0x123 and the original addr, and retry_cnt SHALL be 1.
REQ-032 Same id timing out 3 times with MAX_RETRIES=2: backoffs SHALL be 16 then 32 cycles, the third event SHALL produce err_valid with id 0x123, and fatal_cnt SHALL be 1.
REQ-033 Hold retry_ready=0 for 10 cycles: retry_valid and the payload SHALL stay stable, and completion SHALL occur on the first ready cycle.
REQ-034 Send 10 timeout events back-to-back with the FSM stalled: fifo_full SHALL assert after 8 events and drop_cnt SHALL be 2.
REQ-035 Warning id 0x045: recovery_action SHALL pulse the next cycle with id 0x045; after 0x045 reaches the max count, a warning for it SHALL give no pulse.
REQ-036 Assert rst_n low mid-BACKOFF: all outputs SHALL be 0 and, after release, no retry SHALL be issued.
